controle_jogo_param: RTL and testbench

Parametrised game-control FSM for the note-sequence game, with its counters and timers internal. It plays a growing sequence of notes from an external note memory, waits for and captures each player press, and compares it against memory. It tracks rounds, a lives budget and a player-response timeout. It sits between the note ROM, the button inputs and the buzzer/display datapath.

---
 rtl/controle_jogo_param.sv | 177 +++++++++++++++++
 tb/tb_controle_jogo_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo_param.sv
// Game-control FSM for the note-sequence game: plays a growing note sequence, captures and checks presses.
// Optional player-response timeout enabled by defining TIMEOUT_JOGADA_EN.
module controle_jogo_param #(
  parameter int N_BOTOES     = 4,
  parameter int ADDR_W       = 4,
  parameter int NOTE_CYCLES  = 1000,
  parameter int PLAY_TIMEOUT = 5000,
  parameter int MAX_ERROS    = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                treinamento,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] nota_mem,
  input  logic [ADDR_W-1:0]   num_rodadas,
  output logic [ADDR_W-1:0]   endereco,
  output logic [ADDR_W-1:0]   rodada,
  output logic [N_BOTOES-1:0] nota_saida,
  output logic                tocando,
  output logic                esperando,
  output logic                erro_pulse,
  output logic [7:0]          erros,
  output logic                pronto,
  output logic                acertou,
  output logic                timeout_flag,
  output logic [4:0]          db_estado
);

  localparam logic [4:0] IDLE        = 5'd0;
  localparam logic [4:0] PREP        = 5'd1;
  localparam logic [4:0] ESPERA      = 5'd3;
  localparam logic [4:0] COMPARA     = 5'd5;
  localparam logic [4:0] TOCA        = 5'd7;
  localparam logic [4:0] PROX_NOTA   = 5'd8;
  localparam logic [4:0] FIM_OK      = 5'd10;
  localparam logic [4:0] FIM_RODADA  = 5'd11;
  localparam logic [4:0] FIM_TIMEOUT = 5'd13;
  localparam logic [4:0] ERRO        = 5'd14;
  localparam logic [4:0] FIM_ERRO    = 5'd15;
  localparam logic [4:0] TREINO      = 5'd16;
  localparam logic [4:0] SOLTA       = 5'd18;

  // The timer serves both the note duration and the response window, so it is sized for the larger.
  localparam int TIMER_TOP = (NOTE_CYCLES > PLAY_TIMEOUT) ? NOTE_CYCLES : PLAY_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_TOP) + 1;
  localparam logic [TIMER_W-1:0] NOTE_LAST = TIMER_W'(NOTE_CYCLES - 1);
`ifdef TIMEOUT_JOGADA_EN
  localparam logic [TIMER_W-1:0] PLAY_LAST = TIMER_W'(PLAY_TIMEOUT - 1);
`endif

  logic [4:0]          estado;
  logic [4:0]          estado_prox;
  logic [TIMER_W-1:0]  timer;
  logic [N_BOTOES-1:0] captura;
  logic [ADDR_W-1:0]   ultima_rodada;

  logic ultima_nota;
  logic fim_nota;
  logic nota_certa;
  logic fim_erros;
  logic fim_jogo;

  assign ultima_nota = (endereco == rodada);
  assign fim_nota    = (timer == NOTE_LAST);
  assign nota_certa  = (captura == nota_mem);
  assign fim_erros   = (({1'b0, erros} + 9'd1) == 9'(MAX_ERROS));
  assign fim_jogo    = (rodada == ultima_rodada);

  always_comb begin
    estado_prox = estado;
    case (estado)
      IDLE:        if (jogar) estado_prox = PREP;
      PREP:        estado_prox = treinamento ? TREINO : TOCA;
      TREINO:      if (!treinamento) estado_prox = IDLE;
      TOCA:        if (fim_nota) estado_prox = PROX_NOTA;
      PROX_NOTA:   estado_prox = ultima_nota ? ESPERA : TOCA;
      ESPERA: begin
        if (botoes != '0) estado_prox = SOLTA;
`ifdef TIMEOUT_JOGADA_EN
        else if (timer == PLAY_LAST) estado_prox = FIM_TIMEOUT;
`endif
      end
      SOLTA:       if (botoes == '0) estado_prox = COMPARA;
      COMPARA: begin
        if (!nota_certa)      estado_prox = ERRO;
        else if (ultima_nota) estado_prox = FIM_RODADA;
        else                  estado_prox = ESPERA;
      end
      ERRO:        estado_prox = fim_erros ? FIM_ERRO : TOCA;
      FIM_RODADA:  estado_prox = fim_jogo ? FIM_OK : TOCA;
      FIM_OK, FIM_ERRO, FIM_TIMEOUT:
                   if (jogar) estado_prox = PREP;
      default:     estado_prox = IDLE;
    endcase
  end

  // State, timer and datapath registers; counter updates mirror the transition decisions above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= IDLE;
      timer         <= '0;
      endereco      <= '0;
      rodada        <= '0;
      erros         <= '0;
      captura       <= '0;
      ultima_rodada <= '0;
    end else begin
      estado <= estado_prox;
      if (estado_prox != estado)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;

      case (estado)
        PREP: begin
          endereco      <= '0;
          rodada        <= '0;
          erros         <= '0;
          ultima_rodada <= num_rodadas;
        end
        PROX_NOTA: begin
          if (ultima_nota) endereco <= '0;
          else             endereco <= endereco + 1'b1;
        end
        ESPERA: begin
          if (botoes != '0) captura <= botoes;
        end
        COMPARA: begin
          if (nota_certa && !ultima_nota) endereco <= endereco + 1'b1;
        end
        ERRO: begin
          erros <= erros + 8'd1;
          if (!fim_erros) endereco <= '0;
        end
        FIM_RODADA: begin
          if (!fim_jogo) begin
            rodada   <= rodada + 1'b1;
            endereco <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nota_saida = '0;
    case (estado)
      TOCA:                  nota_saida = nota_mem;
      ESPERA, SOLTA, TREINO: nota_saida = botoes;
      default:               nota_saida = '0;
    endcase
  end

  assign tocando    = (estado == TOCA);
  assign esperando  = (estado == ESPERA);
  assign erro_pulse = (estado == ERRO);
  assign pronto     = (estado == FIM_OK) || (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
  assign acertou    = (estado == FIM_OK);
`ifdef TIMEOUT_JOGADA_EN
  assign timeout_flag = (estado == FIM_TIMEOUT);
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    case (estado)
      IDLE, PREP, ESPERA, COMPARA, TOCA, PROX_NOTA, FIM_OK, FIM_RODADA,
      FIM_TIMEOUT, ERRO, FIM_ERRO, TREINO, SOLTA:
        db_estado = estado;
      default:
        db_estado = 5'd31;
    endcase
  end

endmodule

// File: tb/tb_controle_jogo_param.sv
// Directed bench for controle_jogo_param: NOTE_CYCLES=4, PLAY_TIMEOUT=20, MAX_ERROS=2, two-note memory.
module tb_controle_jogo_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       treinamento = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [3:0] nota_mem;
  logic [3:0] num_rodadas = 4'd1;
  logic [3:0] endereco;
  logic [3:0] rodada;
  logic [3:0] nota_saida;
  logic       tocando;
  logic       esperando;
  logic       erro_pulse;
  logic [7:0] erros;
  logic       pronto;
  logic       acertou;
  logic       timeout_flag;
  logic [4:0] db_estado;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] mem [0:15];
  assign nota_mem = mem[endereco];

  always #5 clock = ~clock;

  controle_jogo_param #(
    .N_BOTOES(4), .ADDR_W(4), .NOTE_CYCLES(4), .PLAY_TIMEOUT(20), .MAX_ERROS(2)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
    .botoes(botoes), .nota_mem(nota_mem), .num_rodadas(num_rodadas),
    .endereco(endereco), .rodada(rodada), .nota_saida(nota_saida),
    .tocando(tocando), .esperando(esperando), .erro_pulse(erro_pulse),
    .erros(erros), .pronto(pronto), .acertou(acertou),
    .timeout_flag(timeout_flag), .db_estado(db_estado)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic j, input logic t, input logic [3:0] b);
    jogar = j;
    treinamento = t;
    botoes = b;
  endtask

  task automatic startGame;
    applyStimulus(1'b1, 1'b0, 4'd0);
    tick;
    checkOutput("start_prep", db_estado, 1);
    checkOutput("start_prep_tocando", tocando, 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    tick;
    checkOutput("start_toca", db_estado, 7);
  endtask

  // Counts cycles with tocando high; ends in PROX_NOTA.
  task automatic playNote(input string tag, input logic [3:0] nota);
    int cnt;
    cnt = 0;
    checkOutput({tag, "_nota"}, nota_saida, nota);
    while (tocando === 1'b1 && cnt < 50) begin
      cnt++;
      tick;
    end
    checkOutput({tag, "_len"}, cnt, 4);
    checkOutput({tag, "_prox"}, db_estado, 8);
  endtask

  task automatic pressNote(input string tag, input logic [3:0] nota, input logic [4:0] exp_state);
    applyStimulus(1'b0, 1'b0, nota);
    tick;
    checkOutput({tag, "_solta"}, db_estado, 18);
    checkOutput({tag, "_echo"}, nota_saida, nota);
    applyStimulus(1'b0, 1'b0, 4'd0);
    tick;
    checkOutput({tag, "_compara"}, db_estado, 5);
    tick;
    checkOutput({tag, "_after"}, db_estado, exp_state);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    mem[0] = 4'b0001;
    mem[1] = 4'b0100;

    tick;
    tick;
    checkOutput("rst_estado", db_estado, 0);
    checkOutput("rst_outs", {endereco, rodada, nota_saida, tocando, esperando, erro_pulse,
                             erros, pronto, acertou, timeout_flag}, 0);
    reset = 1'b0;
    tick;
    checkOutput("idle_hold", db_estado, 0);

    // Full successful game
    startGame();
    playNote("r0n0", 4'b0001);
    tick;
    checkOutput("r0_espera", db_estado, 3);
    checkOutput("r0_esperando", esperando, 1);
    pressNote("r0p0", 4'b0001, 11);
    tick;
    checkOutput("r1_toca", db_estado, 7);
    checkOutput("r1_rodada", rodada, 1);
    playNote("r1n0", 4'b0001);
    tick;
    checkOutput("r1_toca2", db_estado, 7);
    checkOutput("r1_end1", endereco, 1);
    playNote("r1n1", 4'b0100);
    tick;
    checkOutput("r1_espera", db_estado, 3);
    checkOutput("r1_end0", endereco, 0);
    pressNote("r1p0", 4'b0001, 3);
    checkOutput("r1_end_adv", endereco, 1);
    pressNote("r1p1", 4'b0100, 11);
    tick;
    checkOutput("ok_estado", db_estado, 10);
    checkOutput("ok_acertou", acertou, 1);
    checkOutput("ok_pronto", pronto, 1);
    checkOutput("ok_erros", erros, 0);

    // Two wrong presses end the game
    startGame();
    playNote("e0n0", 4'b0001);
    tick;
    pressNote("e0p", 4'b0010, 14);
    checkOutput("e0_pulse", erro_pulse, 1);
    tick;
    checkOutput("e0_pulse_end", erro_pulse, 0);
    checkOutput("e0_erros", erros, 1);
    checkOutput("e0_replay", db_estado, 7);
    checkOutput("e0_end", endereco, 0);
    checkOutput("e0_rodada", rodada, 0);
    playNote("e1n0", 4'b0001);
    tick;
    pressNote("e1p", 4'b0010, 14);
    tick;
    checkOutput("ferro_estado", db_estado, 15);
    checkOutput("ferro_pronto", pronto, 1);
    checkOutput("ferro_acertou", acertou, 0);
    checkOutput("ferro_erros", erros, 2);

    // Held button stays in SOLTA, then a late press at cycle 19
    startGame();
    playNote("h0n0", 4'b0001);
    tick;
    pressNote("h0p", 4'b0001, 11);
    tick;
    playNote("h1n0", 4'b0001);
    tick;
    playNote("h1n1", 4'b0100);
    tick;
    applyStimulus(1'b0, 1'b0, 4'b0001);
    repeat (10) tick;
    checkOutput("hold_solta", db_estado, 18);
    applyStimulus(1'b0, 1'b0, 4'd0);
    tick;
    checkOutput("hold_compara", db_estado, 5);
    tick;
    checkOutput("hold_espera", db_estado, 3);
    checkOutput("hold_end", endereco, 1);
    checkOutput("hold_erros", erros, 0);
    repeat (19) tick;
    checkOutput("late_espera", db_estado, 3);
    applyStimulus(1'b0, 1'b0, 4'b0100);
    tick;
    checkOutput("late_solta", db_estado, 18);
    applyStimulus(1'b0, 1'b0, 4'd0);
    tick;
    tick;
    checkOutput("late_fimrod", db_estado, 11);
    tick;
    checkOutput("late_ok", db_estado, 10);

    // No press in ESPERA
    startGame();
    playNote("t0n0", 4'b0001);
    tick;
    checkOutput("to_espera", db_estado, 3);
    repeat (19) tick;
    checkOutput("to_espera19", db_estado, 3);
    tick;
`ifdef TIMEOUT_JOGADA_EN
    checkOutput("to_estado", db_estado, 13);
    checkOutput("to_flag", timeout_flag, 1);
    checkOutput("to_pronto", pronto, 1);
`else
    repeat (30) tick;
    checkOutput("noto_estado", db_estado, 3);
    checkOutput("noto_flag", timeout_flag, 0);
`endif
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // Reset during TOCA of round 1
    startGame();
    playNote("x0n0", 4'b0001);
    tick;
    pressNote("x0p", 4'b0001, 11);
    tick;
    checkOutput("x1_toca", db_estado, 7);
    checkOutput("x1_rodada", rodada, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("xrst_estado", db_estado, 0);
    checkOutput("xrst_outs", {endereco, rodada, nota_saida, tocando, esperando, erro_pulse,
                              erros, pronto, acertou, timeout_flag}, 0);
    tick;
    reset = 1'b0;
    tick;
    startGame();
    checkOutput("xre_rodada", rodada, 0);
    checkOutput("xre_end", endereco, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;

    // Training mode
    applyStimulus(1'b1, 1'b1, 4'd0);
    tick;
    checkOutput("tr_prep", db_estado, 1);
    applyStimulus(1'b0, 1'b1, 4'd0);
    tick;
    checkOutput("tr_treino", db_estado, 16);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    #1;
    checkOutput("tr_echo", nota_saida, 4'b1000);
    applyStimulus(1'b0, 1'b0, 4'd0);
    tick;
    checkOutput("tr_idle", db_estado, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
